// File: rtl/wdt_apb.sv
// wdt_apb: APB watchdog timer with a programmable prescaler.
// The first expiry raises WDTIntr. A second expiry without a keyed kick enters
// BITE, which asserts WDTRstReq if RSTEN is set and holds it until PRESETn.
//
// Bus handshake: this is a single-cycle APB slave, so PREADY is tied high. A write
// commits on the PCLK edge where PSEL & PENABLE & PWRITE are all high. PRDATA is
// purely combinational from PADDR and does not depend on PSEL or PENABLE.
module wdt_apb #(
    parameter int          XLEN    = 32,
    parameter int          CNT_W   = 32,
    parameter logic [31:0] KICKKEY = 32'hD09F_00D5
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [4:0]        PADDR,
    input  logic [XLEN-1:0]   PWDATA,
    input  logic [XLEN/8-1:0] PSTRB,
    output logic [XLEN-1:0]   PRDATA,
    output logic              PREADY,
    output logic              WDTIntr,
    output logic              WDTRstReq,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WARN = 2'd2,
        S_BITE = 2'd3
    } state_t;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_LOAD   = 3'd1;
    localparam logic [2:0] A_COUNT  = 3'd2;
    localparam logic [2:0] A_KICK   = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    // Register state
    state_t             state_q, state_nxt;
    logic               ctrl_en, ctrl_rsten, ctrl_lock;
    logic [3:0]         ctrl_ps;
    logic [CNT_W-1:0]   load_q, load_nxt;
    logic [CNT_W-1:0]   count_q, count_nxt;
    logic [15:0]        pre_q, pre_nxt;
    logic               st_warn, st_badkey;
    logic               rstreq_q, rstreq_nxt;
    logic               warn_set;

    // Bus decode
    logic [63:0]        wdata_ext;
    logic [7:0]         strb_ext;
    logic [31:0]        wdata;
    logic [3:0]         strb;
    logic               lane_hi;
    logic [2:0]         reg_sel;
    logic               wr_en, ctrl_wr, load_wr, kick_wr, stat_wr;
    logic               kick_ok, kick_bad, en_nxt;
    logic [15:0]        ps_mask;
    logic               tick;
    logic [31:0]        load_ext;
    logic [31:0]        rdata;
    logic [1:0]         unused_paddr;

    assign unused_paddr = PADDR[1:0];

    // Select the 32-bit word lane of the bus; on a 64-bit bus PADDR[2] picks the upper half.
    always_comb begin
        wdata_ext               = '0;
        wdata_ext[XLEN-1:0]     = PWDATA;
        strb_ext                = '0;
        strb_ext[XLEN/8-1:0]    = PSTRB;
        lane_hi                 = (XLEN == 64) && PADDR[2];
        wdata                   = lane_hi ? wdata_ext[63:32] : wdata_ext[31:0];
        strb                    = lane_hi ? strb_ext[7:4]    : strb_ext[3:0];
    end

    // Decode register strobes, kick validity, the effective EN bit and the prescaler tick.
    always_comb begin
        reg_sel  = PADDR[4:2];
        wr_en    = PSEL & PENABLE & PWRITE;
        ctrl_wr  = wr_en && (reg_sel == A_CTRL) && !ctrl_lock;
        load_wr  = wr_en && (reg_sel == A_LOAD) && !ctrl_lock;
        kick_wr  = wr_en && (reg_sel == A_KICK);
        stat_wr  = wr_en && (reg_sel == A_STATUS);
        kick_ok  = kick_wr && (strb == 4'hF) && (wdata == KICKKEY);
        kick_bad = kick_wr && !kick_ok;
        // EN as it will be after this cycle, so an EN write acts without a cycle of lag
        en_nxt   = (ctrl_wr && strb[0]) ? wdata[0] : ctrl_en;
        ps_mask  = ~(16'hFFFF << ctrl_ps);
        tick     = (pre_q & ps_mask) == ps_mask;
    end

    // Byte-lane merge of a LOAD write into the current LOAD value.
    always_comb begin
        load_ext = 32'(load_q);
        for (int b = 0; b < 4; b++) begin
            if (load_wr && strb[b]) begin
                load_ext[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        load_nxt = load_ext[CNT_W-1:0];
    end

    // Watchdog FSM next state: counter, prescaler, WARN set and reset-request capture.
    always_comb begin
        state_nxt  = state_q;
        count_nxt  = count_q;
        pre_nxt    = pre_q;
        warn_set   = 1'b0;
        rstreq_nxt = rstreq_q;
        case (state_q)
            S_IDLE: begin
                if (en_nxt) begin
                    state_nxt = S_RUN;
                    count_nxt = load_q;
                    pre_nxt   = '0;
                end else if (kick_ok) begin
                    count_nxt = load_q;
                    pre_nxt   = '0;
                end
            end
            S_RUN, S_WARN: begin
                pre_nxt = pre_q + 16'd1;
                if (!en_nxt) begin
                    state_nxt = S_IDLE;
                    pre_nxt   = pre_q;
                end else if (kick_ok) begin
                    // a valid kick beats an expiring tick in the same cycle
                    state_nxt = S_RUN;
                    count_nxt = load_q;
                    pre_nxt   = '0;
                end else if (tick) begin
                    if (count_q == '0) begin
                        if (state_q == S_RUN) begin
                            state_nxt = S_WARN;
                            warn_set  = 1'b1;
                            count_nxt = load_q;
                        end else begin
                            state_nxt  = S_BITE;
                            rstreq_nxt = ctrl_rsten;
                        end
                    end else begin
                        count_nxt = count_q - CNT_W'(1);
                    end
                end
            end
            S_BITE: begin
                // frozen until PRESETn
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state register and counters.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= S_IDLE;
            count_q  <= '1;
            pre_q    <= '0;
            rstreq_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            count_q  <= count_nxt;
            pre_q    <= pre_nxt;
            rstreq_q <= rstreq_nxt;
        end
    end

    // CTRL and LOAD registers; LOCK is set-only and blocks further CTRL/LOAD writes.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_en    <= 1'b0;
            ctrl_rsten <= 1'b0;
            ctrl_ps    <= '0;
            ctrl_lock  <= 1'b0;
            load_q     <= '1;
        end else begin
            if (ctrl_wr && strb[0]) begin
                ctrl_en    <= wdata[0];
                ctrl_rsten <= wdata[1];
                ctrl_ps    <= wdata[7:4];
            end
            if (ctrl_wr && strb[1] && wdata[8]) begin
                ctrl_lock <= 1'b1;
            end
            load_q <= load_nxt;
        end
    end

    // STATUS sticky flags: write-one-to-clear, with a same-cycle set taking priority.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            st_warn   <= 1'b0;
            st_badkey <= 1'b0;
        end else begin
            st_warn   <= warn_set | (st_warn & ~(stat_wr & strb[0] & wdata[0]));
            st_badkey <= kick_bad | (st_badkey & ~(stat_wr & strb[0] & wdata[1]));
        end
    end

    // Read mux, replicated across both halves of a 64-bit bus.
    always_comb begin
        case (reg_sel)
            A_CTRL:   rdata = {23'b0, ctrl_lock, ctrl_ps, 2'b00, ctrl_rsten, ctrl_en};
            A_LOAD:   rdata = 32'(load_q);
            A_COUNT:  rdata = 32'(count_q);
            A_STATUS: rdata = {28'b0, state_q, st_badkey, st_warn};
            default:  rdata = 32'b0;
        endcase
        PRDATA = {(XLEN/32){rdata}};
    end

    assign PREADY    = 1'b1;
    assign WDTIntr   = st_warn;
    assign WDTRstReq = rstreq_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wdt_apb.sv
// tb_wdt_apb: self-checking bench for wdt_apb (32-bit instance plus a 64-bit instance for lane tests).
module tb_wdt_apb;

    localparam logic [31:0] KEY = 32'hD09F_00D5;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        psel, psel64, penable, pwrite;
    logic [4:0]  paddr;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;

    logic [31:0] prdata;
    logic        pready, intr, rstreq;
    logic [1:0]  dbg;
    logic [63:0] prdata64;
    logic        pready64, intr64, rstreq64;
    logic [1:0]  dbg64;

    wdt_apb #(.XLEN(32)) u_dut (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]), .PRDATA(prdata),
        .PREADY(pready), .WDTIntr(intr), .WDTRstReq(rstreq), .dbg_state(dbg)
    );

    wdt_apb #(.XLEN(64)) u_dut64 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel64), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata64),
        .PREADY(pready64), .WDTIntr(intr64), .WDTRstReq(rstreq64), .dbg_state(dbg64)
    );

    // ---------------- scoreboard ----------------
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_q(input string name, input logic [31:0] act);
        logic [31:0] e;
        e = exp_q.pop_front();
        check(name, act, e);
    endtask

    // ---------------- reference model (spec rules, 32-bit instance) ----------------
    bit          m_en, m_rsten, m_lock, m_warn, m_badkey, m_rstreq;
    int          m_ps, m_state;
    int unsigned m_pre;
    logic [31:0] m_load, m_count;

    task automatic model_reset();
        m_en = 0; m_rsten = 0; m_lock = 0; m_warn = 0; m_badkey = 0; m_rstreq = 0;
        m_ps = 0; m_state = 0; m_pre = 0; m_load = '1; m_count = '1;
    endtask

    task automatic model_step();
        logic [31:0] d;
        logic [3:0]  s;
        int          r;
        int unsigned period;
        bit wr, ctrl_ok, load_ok, kick, good, new_en, tick;
        d = pwdata[31:0]; s = pstrb[3:0]; r = int'(paddr[4:2]);
        wr      = psel && penable && pwrite;
        ctrl_ok = wr && r == 0 && !m_lock;
        load_ok = wr && r == 1 && !m_lock;
        kick    = wr && r == 3;
        good    = kick && s == 4'hF && d == KEY;
        new_en  = (ctrl_ok && s[0]) ? d[0] : m_en;
        period  = 1 << m_ps;
        tick    = (m_pre % period) == period - 1;
        if (wr && r == 4 && s[0] && d[0]) m_warn = 0;
        if (wr && r == 4 && s[0] && d[1]) m_badkey = 0;
        if (kick && !good) m_badkey = 1;
        case (m_state)
            0: begin
                if (new_en) begin m_state = 1; m_count = m_load; m_pre = 0; end
                else if (good) begin m_count = m_load; m_pre = 0; end
            end
            1, 2: begin
                if (!new_en) m_state = 0;
                else if (good) begin m_state = 1; m_count = m_load; m_pre = 0; end
                else begin
                    m_pre = (m_pre + 1) % 65536;
                    if (tick) begin
                        if (m_count != 0) m_count = m_count - 1;
                        else if (m_state == 1) begin m_state = 2; m_warn = 1; m_count = m_load; end
                        else begin m_state = 3; m_rstreq = m_rsten; end
                    end
                end
            end
            default: ;
        endcase
        if (ctrl_ok && s[0]) begin m_en = d[0]; m_rsten = d[1]; m_ps = int'(d[7:4]); end
        if (ctrl_ok && s[1] && d[8]) m_lock = 1;
        for (int b = 0; b < 4; b++)
            if (load_ok && s[b]) m_load[8*b +: 8] = d[8*b +: 8];
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic apb_wr(input bit sel64, input logic [4:0] a, input logic [63:0] d, input logic [7:0] s);
        tick_cycle();
        psel = !sel64; psel64 = sel64; penable = 1'b0; pwrite = 1'b1;
        paddr = a; pwdata = d; pstrb = s;
        tick_cycle();
        penable = 1'b1;
        tick_cycle();
        psel = 1'b0; psel64 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic peek(input logic [4:0] a, output logic [31:0] d);
        paddr = a;
        #1;
        d = prdata;
    endtask

    task automatic peek64(input logic [4:0] a, output logic [63:0] d);
        paddr = a;
        #1;
        d = prdata64;
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        string       name;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [4:0]  raddr;
        logic [31:0] rexp;
    } wr_vec_t;

    rd_vec_t rst_tbl[8];
    wr_vec_t wr_tbl[14];

    initial begin : safety
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] v;
        logic [63:0] v64;
        int          n, op;

        rst_tbl = '{
            '{5'h00, 32'h0}, '{5'h04, 32'hFFFF_FFFF}, '{5'h08, 32'hFFFF_FFFF}, '{5'h0C, 32'h0},
            '{5'h10, 32'h0}, '{5'h14, 32'h0},         '{5'h18, 32'h0},         '{5'h1C, 32'h0}
        };
        wr_tbl = '{
            '{"load_full",    5'h04, 32'h1234_5678, 4'hF, 5'h04, 32'h1234_5678},
            '{"load_byte0",   5'h04, 32'hAABB_CCDD, 4'h1, 5'h04, 32'h1234_56DD},
            '{"load_hi",      5'h04, 32'hAABB_CCDD, 4'hC, 5'h04, 32'hAABB_56DD},
            '{"ctrl_fields",  5'h00, 32'h0000_00FE, 4'h1, 5'h00, 32'h0000_00F2},
            '{"ctrl_nolane",  5'h00, 32'h0000_0000, 4'h2, 5'h00, 32'h0000_00F2},
            '{"count_ro",     5'h08, 32'h0000_0000, 4'hF, 5'h08, 32'hFFFF_FFFF},
            '{"hole_ignored", 5'h14, 32'hFFFF_FFFF, 4'hF, 5'h14, 32'h0},
            '{"badkey_data",  5'h0C, 32'h0000_1234, 4'hF, 5'h10, 32'h2},
            '{"badkey_w1c",   5'h10, 32'h0000_0002, 4'h1, 5'h10, 32'h0},
            '{"badkey_strb",  5'h0C, KEY,           4'h7, 5'h10, 32'h2},
            '{"status_clr",   5'h10, 32'hFFFF_FFFF, 4'hF, 5'h10, 32'h0},
            '{"goodkey_idle", 5'h0C, KEY,           4'hF, 5'h10, 32'h0},
            '{"kick_reads0",  5'h1C, 32'hFFFF_FFFF, 4'hF, 5'h0C, 32'h0},
            '{"ctrl_clear",   5'h00, 32'h0000_0000, 4'hF, 5'h00, 32'h0}
        };

        psel = 0; psel64 = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
        do_reset();

        // reset values
        for (int i = 0; i < 8; i++) begin
            peek(rst_tbl[i].addr, v);
            check($sformatf("reset_reg_%0h", rst_tbl[i].addr), v, rst_tbl[i].exp);
        end
        check("reset_pready", 32'(pready), 32'd1);
        check("reset_intr", 32'(intr), 32'd0);
        check("reset_rstreq", 32'(rstreq), 32'd0);

        // register write/readback table
        for (int i = 0; i < 14; i++) begin
            apb_wr(0, wr_tbl[i].waddr, 64'(wr_tbl[i].wdata), 8'(wr_tbl[i].wstrb));
            peek(wr_tbl[i].raddr, v);
            check(wr_tbl[i].name, v, wr_tbl[i].rexp);
        end

        // PS=0, LOAD=5: WARN six cycles after RUN entry, BITE six ticks later
        do_reset();
        apb_wr(0, 5'h04, 64'd5, 8'hF);
        apb_wr(0, 5'h00, 64'h3, 8'hF);
        peek(5'h08, v); check("run_entry_count", v, 32'd5);
        peek(5'h10, v); check("run_entry_status", v, 32'h4);
        n = 0;
        while (!intr && n < 40) begin tick_cycle(); n++; end
        check("warn_latency", 32'(n), 32'd6);
        peek(5'h10, v); check("warn_status", v, 32'h9);
        peek(5'h08, v); check("warn_count_reload", v, 32'd5);
        n = 0;
        while (!rstreq && n < 40) begin tick_cycle(); n++; end
        check("bite_latency", 32'(n), 32'd6);
        apb_wr(0, 5'h00, 64'h0, 8'hF);
        repeat (10) tick_cycle();
        check("bite_rstreq_held", 32'(rstreq), 32'd1);
        check("bite_state_held", 32'(dbg), 32'd3);
        rst_n = 1'b0;
        #1;
        check("rstreq_cleared_by_reset", 32'(rstreq), 32'd0);
        check("intr_cleared_by_reset", 32'(intr), 32'd0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // PS=3, LOAD=2: tick every 8 cycles, keyed and bad kicks in WARN/RUN
        apb_wr(0, 5'h04, 64'd2, 8'hF);
        apb_wr(0, 5'h00, 64'h31, 8'hF);
        n = 0;
        while (dbg != 2'd2 && n < 60) begin tick_cycle(); n++; end
        check("ps3_warn_latency", 32'(n), 32'd24);
        apb_wr(0, 5'h0C, 64'(KEY), 8'hF);
        peek(5'h10, v); check("kick_in_warn_status", v, 32'h5);
        peek(5'h08, v); check("kick_in_warn_count", v, 32'd2);
        n = 0;
        v = '0;
        while (n < 40) begin
            tick_cycle(); n++;
            peek(5'h08, v);
            if (v == 32'd1) break;
        end
        check("ps3_tick_period", 32'(n), 32'd8);
        apb_wr(0, 5'h0C, 64'h1234, 8'hF);
        peek(5'h08, v); check("badkick_no_reload", v, 32'd1);
        peek(5'h10, v); check("badkick_status", v, 32'h7);

        // kick lands on the expiring tick in RUN: kick wins
        do_reset();
        apb_wr(0, 5'h04, 64'd1, 8'hF);
        apb_wr(0, 5'h00, 64'h31, 8'hF);
        repeat (13) tick_cycle();
        apb_wr(0, 5'h0C, 64'(KEY), 8'hF);
        peek(5'h10, v); check("kick_vs_expiry_status", v, 32'h4);
        peek(5'h08, v); check("kick_vs_expiry_count", v, 32'd1);

        // 64-bit lanes before lock, then lock on both instances
        do_reset();
        apb_wr(1, 5'h04, {32'h0000_0007, 32'hFFFF_FFFF}, 8'hF0);
        peek64(5'h04, v64);
        check("x64_load_lo", v64[31:0], 32'd7);
        check("x64_load_hi", v64[63:32], 32'd7);
        apb_wr(1, 5'h04, {32'h0, 32'h55}, 8'h0F);
        peek64(5'h04, v64); check("x64_wrong_lane", v64[63:32], 32'd7);
        apb_wr(1, 5'h00, {32'h0, 32'h100}, 8'h0F);
        apb_wr(1, 5'h04, {32'd9, 32'd9}, 8'hF0);
        peek64(5'h04, v64); check("x64_locked_load", v64[31:0], 32'd7);
        peek64(5'h00, v64); check("x64_ctrl_lock", v64[63:32], 32'h100);

        apb_wr(0, 5'h00, 64'h101, 8'hF);
        apb_wr(0, 5'h00, 64'h0, 8'hF);
        apb_wr(0, 5'h04, 64'd9, 8'hF);
        peek(5'h00, v); check("lock_ctrl_ignored", v, 32'h101);
        peek(5'h04, v); check("lock_load_ignored", v, 32'hFFFF_FFFF);
        check("lock_still_run", 32'(dbg), 32'd1);
        apb_wr(0, 5'h0C, 64'(KEY), 8'hF);
        peek(5'h08, v); check("lock_kick_works", v, 32'hFFFF_FFFF);
        apb_wr(0, 5'h0C, 64'h1234, 8'hF);
        peek(5'h10, v); check("lock_badkey", v, 32'h6);
        apb_wr(0, 5'h10, 64'h2, 8'h1);
        peek(5'h10, v); check("lock_w1c_works", v, 32'h4);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1: apb_wr(0, 5'h00,
                             64'({$urandom_range(0, 2) == 0 ? 4'd0 : 4'($urandom_range(0, 2)), 2'b00,
                                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)}),
                             ($urandom_range(0, 1) == 1) ? 8'hF : 8'h1);
                2:    apb_wr(0, 5'h04, 64'($urandom_range(0, 6)), 8'hF);
                3, 4: apb_wr(0, 5'h0C, ($urandom_range(0, 1) == 1) ? 64'(KEY) : 64'($urandom),
                             ($urandom_range(0, 3) == 0) ? 8'h7 : 8'hF);
                5:    apb_wr(0, 5'h10, 64'($urandom_range(0, 3)), 8'h1);
                6:    if ($urandom_range(0, 3) == 0) do_reset(); else tick_cycle();
                default: repeat ($urandom_range(1, 12)) tick_cycle();
            endcase
            exp_q.push_back(m_count);
            exp_q.push_back({28'b0, 2'(m_state), m_badkey, m_warn});
            exp_q.push_back({23'b0, m_lock, 4'(m_ps), 2'b00, m_rsten, m_en});
            exp_q.push_back(32'(m_warn));
            exp_q.push_back(32'(m_rstreq));
            peek(5'h08, v); check_q("rnd_count", v);
            peek(5'h10, v); check_q("rnd_status", v);
            peek(5'h00, v); check_q("rnd_ctrl", v);
            check_q("rnd_intr", 32'(intr));
            check_q("rnd_rstreq", 32'(rstreq));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
